// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled 8N1 UART receiver feeding a small byte buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register.
module uart_rx_os16 #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic       baud_tick,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] dout,
    output logic       dvalid,
    output logic       ferr,
    output logic       overrun,
    output logic       rx_busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;

    logic       rx_meta_q, rx_s_q;
    logic [2:0] state_q, state_d;
    logic [3:0] os_cnt_q, os_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic       push_q, push_d;
    logic       ferr_q, ferr_d, ferr_set;
    logic       overrun_q, overrun_d, ovr_set;
    logic       pop, full, wr;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // NOTE: next-state logic uses blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d  = S_START;
                        os_cnt_d = 4'd0;
                    end
                end
                S_START: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    // Confirmation lands 7 ticks after detection: the tick on which os_cnt reaches 7.
                    if (os_cnt_q == 4'd6) begin
                        if (!rx_s_q) begin
                            state_d   = S_DATA;
                            os_cnt_d  = 4'd0;
                            bit_idx_d = 3'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        shreg_d[bit_idx_q] = rx_s_q;
                        if (bit_idx_q == 3'd7) state_d = S_STOP;
                        else                   bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                S_STOP: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        if (rx_s_q) begin
                            push_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_d  = S_WAIT_HI;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            os_cnt_q  <= 4'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        pop      = rd_en && (count_q != '0);
        full     = (count_q == FULL_CNT);
        wr       = push_q && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is reset as well so the head byte reads 0x00 straight out of reset.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mem_q    <= '{default: 8'h00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout   = mem_q[rd_ptr_q];
    assign dvalid = (count_q != '0);
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    always_comb begin
        pop     = rd_en && valid_q;
        full    = valid_q;
        wr      = push_q && (!full || pop);
        hold_d  = wr ? shreg_q : hold_q;
        valid_d = wr || (valid_q && !pop);
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign dout   = hold_q;
    assign dvalid = valid_q;
`endif

    // A set in the same cycle as clr_err wins; neither flag clears on its own.
    always_comb begin
        ovr_set   = push_q && full && !pop;
        ferr_d    = ferr_set || (ferr_q && !clr_err);
        overrun_d = ovr_set || (overrun_q && !clr_err);
    end

    assign ferr    = ferr_q;
    assign overrun = overrun_q;
    assign rx_busy = (state_q != S_IDLE);

    a_fifo_depth_legal: assert property (@(posedge clk)
        (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0));

endmodule
